// File: rtl/bus_capture_rx.sv
// ---------------------------------------------------------------------------
// bus_capture_rx
//
// Receive side of the shared 7-bit tri-state data bus. The block watches the
// driver's active-low enable line. Once the enable has been low for
// SETTLE_CYCLES consecutive sampled edges after the bus turned around, it
// captures exactly one word for that drive window. Captured words go into a
// small circular FIFO, and a valid/ready consumer drains that FIFO.
//
// Parameters
//   SETTLE_CYCLES  consecutive low samples of bus_drv_n before capture (1..15)
//   DEPTH          FIFO depth in words, power of two (2..8)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus_data    shared bus value, meaningful only while driven
//   bus_drv_n   bus driver enable (0 = bus driven), synchronous to clk
//   out_data    FIFO head word (holds stale data while out_valid is 0)
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts out_data when out_valid is also high
//   fifo_count  number of words held, 0..DEPTH
//   overflow    sticky: a captured word was dropped because the FIFO was full
//   clr_ovf     synchronous clear for overflow (a same-edge drop wins)
// ---------------------------------------------------------------------------
module bus_capture_rx #(
  parameter int SETTLE_CYCLES = 2,
  parameter int DEPTH         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] bus_data,
  input  logic       bus_drv_n,
  output logic [6:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] fifo_count,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [3:0]  SETTLE_C = 4'(SETTLE_CYCLES);
  localparam logic [3:0]  DEPTH_C  = 4'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_WAIT    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;

  logic [6:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  logic          wr_s;
  logic          pop_s;
  logic          full_s;
  logic          push_s;
  logic          drop_s;

  // Window FSM: counts settle cycles and raises a single-cycle capture strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus_drv_n) begin
          state_d = ST_SETTLE;
          cnt_d   = 4'd1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      ST_SETTLE: begin
        if (bus_drv_n) begin
          // Window closed before the bus settled: drop it silently.
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == SETTLE_C) begin
          wr_s    = 1'b1;
          state_d = ST_WAIT;
        end else if (cnt_q != 4'd15) begin
          cnt_d   = cnt_q + 4'd1;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      ST_WAIT: begin
        // One word per window: sit here until the driver lets go.
        if (bus_drv_n) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state and settle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO control: pop/push qualification, pointer, occupancy and flag next-state.
  always_comb begin
    pop_s  = (count_q != 4'd0) && out_ready;
    full_s = (count_q == DEPTH_C);
    // A full FIFO still takes the word when the head leaves on the same edge.
    push_s = wr_s && (!full_s || pop_s);
    drop_s = wr_s && full_s && !pop_s;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase

    valid_d = (count_d != 4'd0);

    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO pointers, occupancy, valid and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads 7'h00 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 7'h00;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= bus_data;
    end
  end

  assign out_data   = mem_q[rd_ptr_q];
  assign out_valid  = valid_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/bus_capture_rx.md
# bus_capture_rx

Receive-side companion for the shared 7-bit tri-state data bus. The bus driver places data on the bus while its active-low enable is low. This block watches the same enable line and waits a programmable settle time after the bus turns around from high-Z. It then samples one word per drive window and queues the words in a small FIFO. Downstream logic reads them over a valid/ready handshake.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: number of consecutive sampled-low cycles of bus_drv_n before capture. Legal range 1..15.
- DEPTH, default 4: FIFO depth in words. Must be a power of 2, range 2..8.

Ports:
- clk  in  1  single system clock; all logic uses the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- bus_data  in  7  shared bus value. Valid only while the bus is driven.
- bus_drv_n  in  1  bus driver enable, the same line that gates the driver. 0 means the bus is driven. Synchronous to clk.
- out_data  out  7  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid and out_ready are both high at a clock edge.
- fifo_count  out  4  number of words held, 0..DEPTH.
- overflow  out  1  sticky flag: a captured word was dropped.
- clr_ovf  in  1  synchronous clear for overflow.

## Operation
- FSM states and transitions:
  - IDLE:
    - bus_drv_n sampled 0 -> SETTLE, with cnt set to 1.
  - SETTLE:
    - bus_drv_n sampled 1 -> IDLE. This is an aborted window: no write, no flag.
    - bus_drv_n 0 and cnt == SETTLE_CYCLES -> capture, then go to WAIT_RELEASE.
    - otherwise cnt increments.
  - WAIT_RELEASE:
    - stays here while bus_drv_n is 0.
    - bus_drv_n sampled 1 -> IDLE.
- Capture: bus_data sampled at the capture edge is presented as a write to the FIFO. Exactly one word is captured per drive window, however long the window lasts.
- cnt is 4 bits and saturates at no more than 15. It is only meaningful in SETTLE.
- FIFO:
  - Circular buffer with read and write pointers of log2(DEPTH) bits. Pointers wrap modulo DEPTH.
  - fifo_count tracks occupancy.
  - Pop happens when out_valid and out_ready are both high.
  - A write while full with no same-edge pop drops the word, sets overflow, and leaves the contents unchanged.
  - A write while full with a same-edge pop is accepted; fifo_count stays at DEPTH.
  - A write and a pop on the same edge, not full and not empty, leave fifo_count unchanged.
  - No bypass: a word written at edge k appears at out_data after edge k.
- out_data always equals the word at the read pointer.
  - It holds its last value when the FIFO is empty; it is not cleared.
  - The consumer must ignore it while out_valid is 0.
- Overflow flag:
  - clr_ovf clears overflow at the next edge.
  - If a drop occurs on the same edge as clr_ovf, the set wins and overflow stays 1.

## Timing
- Reset state, applied immediately on rst_n low: state IDLE, cnt 0, pointers 0, fifo_count 0, out_valid 0, out_data 7'h00, overflow 0.
- Reset mid-window or with the FIFO non-empty discards all contents. After release, the FSM is in IDLE. If bus_drv_n is already 0 at that point, a full settle sequence starts from the first sampled edge.
- Capture latency:
  - bus_drv_n first sampled low at edge k means capture at edge k+SETTLE_CYCLES.
  - out_valid is high in the cycle after that edge if the FIFO was empty.
- Minimum drive window for a capture: SETTLE_CYCLES+1 consecutive edges with bus_drv_n low. Shorter windows are aborted silently.
- Back-to-back windows: bus_drv_n high for one sampled edge is enough to return to IDLE. The next low edge starts a new window.
- Throughput: at most one word per SETTLE_CYCLES+2 cycles.
- Read side: one pop per cycle maximum. out_ready has no effect when out_valid is 0.
- fifo_count, out_valid and overflow are all registered outputs. Each updates on the same edge as the event that causes it.

## Test plan
- Reset and single window (SETTLE_CYCLES=2): drive 7'h5A with bus_drv_n low for 5 cycles, out_ready 0.
  - Required: a word is written on the 2nd edge after the first low sample.
  - Required: out_valid=1, out_data=7'h5A, fifo_count=1.
  - Required: exactly one word in total.
- Aborted window: bus_drv_n low for 2 edges only, then high.
  - Required: fifo_count stays 0, out_valid stays 0, overflow stays 0.
- Fill and overflow (DEPTH=4): five windows carrying 7'h01..7'h05 with out_ready 0.
  - Required: fifo_count=4 and overflow=1.
  - Required: draining yields 01, 02, 03, 04. Word 05 is lost.
  - Then assert clr_ovf for one cycle -> overflow=0.
- Full with simultaneous pop: FIFO full, capture edge coincides with out_ready=1.
  - Required: the word is accepted, overflow stays 0, fifo_count stays 4.
  - Required: the pointer wrap gives correct order over 8+ words.
- Clear/set collision: clr_ovf=1 on the same edge as a dropped write.
  - Required: overflow remains 1.
- Reset mid-operation: assert rst_n low while in SETTLE with 3 words queued.
  - Required: all outputs are at reset values immediately.
  - Required: after release, with bus_drv_n held low and 7'h3C on the bus, one capture of 7'h3C after SETTLE_CYCLES edges.
